// File: rtl/code_dec_pkg.sv
// rtl/code_dec_pkg.sv - shared constants and entry type for the code decoder buffer
//
// Purpose: code width, default highest legal code, error counter width,
//          the default buffer-entry struct and the parity helper.
// Ports:   none (package).

package code_dec_pkg;

    localparam int CODE_W       = 5;
    localparam int MAX_CODE_DEF = 19;
    localparam int ERR_CNT_W    = 8;
    localparam int ONEHOT_W_DEF = MAX_CODE_DEF + 1;

    typedef struct packed {
        logic [ONEHOT_W_DEF-1:0] onehot;
        logic                    err;
    } dec_entry_t;

    // Even parity bit: the value that makes the total count of ones even.
    function automatic logic parity_even(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

endpackage

// File: rtl/dec_entry_fifo.sv
// rtl/dec_entry_fifo.sv - DEPTH-entry FIFO storing decoded entries
//
// Purpose: ordered storage with read/write pointers and an occupancy count.
//          A push while full and a pop while empty are ignored.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   push       write push_data when not full
//   push_data  entry to store
//   pop        drop the head entry when not empty
//   head_data  entry at the read pointer (unqualified; check empty)
//   empty      occupancy == 0
//   full       occupancy == DEPTH

module dec_entry_fifo
    import code_dec_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = dec_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head_data,
    output logic   empty,
    output logic   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_push;
    logic               do_pop;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == DEPTH_C);
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/code_decoder_buf.sv
// rtl/code_decoder_buf.sv - binary-to-one-hot decoder with buffered output
//
// Purpose: decodes in_code to a one-hot word, flags illegal codes, buffers
//          the result in a small FIFO and counts accepted illegal codes.
// Option:  CODE_DECODER_BUF_PARITY_EN adds in_par (even parity over in_code);
//          a parity mismatch makes the code illegal.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    in_code presented
//   in_ready    buffer has room (registered state only)
//   in_code     binary code
//   in_par      even-parity bit (option only)
//   out_valid   head entry valid
//   out_ready   consumer takes head entry
//   out_onehot  decoded word at head, 0 when empty
//   out_err     head entry came from an illegal code, 0 when empty
//   err_cnt     saturating count of accepted illegal codes

module code_decoder_buf
    import code_dec_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_CODE = MAX_CODE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    in_code,
`ifdef CODE_DECODER_BUF_PARITY_EN
    input  logic                 in_par,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAX_CODE:0]    out_onehot,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic [MAX_CODE:0] onehot;
        logic              err;
    } entry_t;

    localparam logic [CODE_W-1:0] MAX_CODE_C = CODE_W'(MAX_CODE);

    logic                 live_q, live_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 code_legal;
    logic                 par_ok;
    logic                 push;
    logic                 fifo_empty;
    logic                 fifo_full;
    entry_t               new_entry;
    entry_t               head_entry;

`ifdef CODE_DECODER_BUF_PARITY_EN
    assign par_ok = (in_par == parity_even(in_code));
`else
    assign par_ok = 1'b1;
`endif

    assign code_legal = (in_code <= MAX_CODE_C) && par_ok;

    // live_q holds in_ready low through reset and lets it rise on the
    // first edge after release.
    assign in_ready = live_q && !fifo_full;
    assign push     = in_valid && in_ready;

    always_comb begin
        new_entry.onehot = '0;
        new_entry.err    = !code_legal;
        for (int i = 0; i <= MAX_CODE; i++) begin
            if (code_legal && (in_code == CODE_W'(i))) begin
                new_entry.onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        live_d    = 1'b1;
        err_cnt_d = err_cnt_q;
        if (push && new_entry.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            live_q    <= live_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    dec_entry_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (new_entry),
        .pop       (out_ready),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid  = !fifo_empty;
    assign out_onehot = out_valid ? head_entry.onehot : '0;
    assign out_err    = out_valid ? head_entry.err    : 1'b0;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_code_decoder_buf.sv
// tb/tb_code_decoder_buf.sv - self-checking bench for code_decoder_buf

module tb_code_decoder_buf;

    localparam int DEPTH    = 2;
    localparam int MAX_CODE = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_code;
    logic        in_par;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_onehot;
    logic        out_err;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    code_decoder_buf #(.DEPTH(DEPTH), .MAX_CODE(MAX_CODE)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
`ifdef CODE_DECODER_BUF_PARITY_EN
        .in_par     (in_par),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of expected entries plus counters.
    typedef struct {
        logic [19:0] oh;
        logic        err;
    } m_entry_t;

    m_entry_t mq[$];
    m_entry_t m_new;
    int       m_err  = 0;
    bit       m_live = 0;
    bit       m_push;
    bit       m_pop;
    bit       m_legal;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_err  = 0;
            m_live = 0;
        end else begin
            m_push = in_valid && m_live && (mq.size() < DEPTH);
            m_pop  = out_ready && (mq.size() > 0);
            m_legal = (int'(in_code) <= MAX_CODE);
`ifdef CODE_DECODER_BUF_PARITY_EN
            if (in_par != ^in_code) m_legal = 0;
`endif
            m_new.oh  = m_legal ? (20'd1 << in_code) : 20'd0;
            m_new.err = !m_legal;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(m_new);
                if (m_new.err && m_err < 255) m_err++;
            end
            m_live = 1;
        end
    end

    always @(negedge clk) begin
        check("cyc_out_valid", out_valid, (mq.size() > 0));
        check("cyc_in_ready", in_ready, (m_live && mq.size() < DEPTH));
        check("cyc_out_onehot", out_onehot, (mq.size() > 0) ? mq[0].oh : 20'd0);
        check("cyc_out_err", out_err, (mq.size() > 0) ? mq[0].err : 1'b0);
        check("cyc_err_cnt", err_cnt, m_err);
    end

    task automatic drive(input logic [4:0] code);
        in_valid = 1'b1;
        in_code  = code;
        in_par   = ^code;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_code = '0; in_par = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_onehot", out_onehot, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset = 1'b1;
        #1 check("ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        check("ready_after_edge", in_ready, 1);

        // code 5 -> bit 5 one cycle later
        out_ready = 1'b1;
        drive(5'd5);
        check("code5_onehot", out_onehot, 32'h00020);
        check("code5_err", out_err, 0);
        check("code5_valid", out_valid, 1);
        @(posedge clk); #1;
        check("code5_popped", out_valid, 0);

        // illegal code 25
        drive(5'd25);
        check("code25_onehot", out_onehot, 0);
        check("code25_err", out_err, 1);
        check("code25_errcnt", err_cnt, 1);
        @(posedge clk); #1;

        // fill with 3, 7; 9 refused; drain in order
        out_ready = 1'b0;
        drive(5'd3);
        check("fill1_ready", in_ready, 1);
        drive(5'd7);
        check("full_ready", in_ready, 0);
        drive(5'd9);
        check("head_is_3", out_onehot, 32'h00008);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("head_is_7", out_onehot, 32'h00080);
        @(posedge clk); #1;
        check("drained_valid", out_valid, 0);

        // full with simultaneous push and pop: push refused
        out_ready = 1'b0;
        drive(5'd1);
        drive(5'd2);
        check("full2_ready", in_ready, 0);
        in_valid = 1'b1; in_code = 5'd11; in_par = ^in_code; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("pop_frees_ready", in_ready, 1);
        check("head_is_2", out_onehot, 32'h00004);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("code11_refused", out_valid, 0);

        // sweep every code with an irregular consumer
        for (int c = 0; c < 32; c++) begin
            in_valid  = 1'b1;
            in_code   = 5'(c);
            in_par    = ^in_code;
            out_ready = (c % 3 != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // saturate err_cnt
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_code  = 5'(20 + (i % 12));
            in_par   = ^in_code;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("errcnt_sat", err_cnt, 255);
        @(posedge clk); #1;

`ifdef CODE_DECODER_BUF_PARITY_EN
        in_valid = 1'b1; in_code = 5'd3; in_par = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("par_bad_err", out_err, 1);
        check("par_bad_onehot", out_onehot, 0);
        @(posedge clk); #1;
`endif

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(5'd4);
        drive(5'd6);
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_errcnt", err_cnt, 0);
        check("async_rst_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
